// File: rtl/illm_d1_arb_if.sv
// Valid/back-pressure stream bundle used for every port group of illm_d1_arb.
// A transfer happens in a cycle with v=1 and b=0; e=1 marks an end-of-stream
// token whose d is don't-care.
interface illm_d1_arb_if;
    logic [127:0] d;
    logic         e;
    logic         v;
    logic         b;

    modport master (output d, output e, output v, input b);
    modport slave  (input d, input e, input v, output b);
endinterface

// File: rtl/illm_d1_arb.sv
// illm_d1_arb: shares one 1-D IDCT between two requesters.
// Grants are issued as bursts of up to BURST vectors. A tag FIFO of depth
// TAGDEPTH remembers which requester owns each result in flight, and it steers
// the IDCT results back to q0/q1. An end-of-stream token from a requester
// retires it permanently. Its own eos is emitted on its q stream once all of
// its results have drained.
// Build option: define ILLM_D1_ARB_PRIO_EN to resolve IDLE ties to requester 0
// every time. Leave it undefined to alternate ties round-robin.
module illm_d1_arb #(
    parameter int BURST    = 8,
    parameter int TAGDEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    illm_d1_arb_if.slave  r0,
    illm_d1_arb_if.slave  r1,
    illm_d1_arb_if.master x,
    illm_d1_arb_if.slave  y,
    illm_d1_arb_if.master q0,
    illm_d1_arb_if.master q1,
    output logic          err
);

    localparam int         PW        = $clog2(TAGDEPTH);
    localparam int         OW        = $clog2(TAGDEPTH + 1);
    localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t         r_state;
    state_t         w_nextState;

    logic           r_owner;
    logic [3:0]     r_count;
    logic [1:0]     r_done;
    logic [1:0]     r_eosSent;
    logic [OW-1:0]  r_outst [2];
    logic           r_err;
    logic           r_tagMem [TAGDEPTH];
    logic [PW:0]    r_wrPtr;
    logic [PW:0]    r_rdPtr;

    logic [1:0]     w_reqV;
    logic [1:0]     w_reqE;
    logic [127:0]   w_reqD [2];
    logic [1:0]     w_elig;
    logic           w_tieGrant;
    logic           w_grant;
    logic           w_inBurst;
    logic           w_ownV;
    logic           w_ownE;
    logic [127:0]   w_ownD;
    logic           w_ownB;
    logic           w_tagEmpty;
    logic           w_tagFull;
    logic           w_headTag;
    logic           w_headB;
    logic           w_xFire;
    logic           w_eosTake;
    logic           w_lastBeat;
    logic           w_yRoute;
    logic           w_yFire;
    logic           w_yBad;
    logic [1:0]     w_qB;
    logic [1:0]     w_eosOut;
    logic [1:0]     w_eosFire;
    logic [1:0]     w_outInc;
    logic [1:0]     w_outDec;

    assign w_reqV    = {r1.v, r0.v};
    assign w_reqE    = {r1.e, r0.e};
    assign w_reqD[0] = r0.d;
    assign w_reqD[1] = r1.d;
    assign w_qB      = {q1.b, q0.b};

    // A retired requester can never win arbitration again.
    assign w_elig = w_reqV & ~r_done;

`ifdef ILLM_D1_ARB_PRIO_EN
    assign w_tieGrant = 1'b0;
`else
    assign w_tieGrant = ~r_owner;
`endif

    assign w_grant = (w_elig == 2'b11) ? w_tieGrant : w_elig[1];

    assign w_inBurst = (r_state == ST_BURST);
    assign w_ownV    = w_reqV[r_owner];
    assign w_ownE    = w_reqE[r_owner];
    assign w_ownD    = w_reqD[r_owner];

    // Full is taken from registered pointers, so a same-cycle pop cannot
    // open a slot for the issue side.
    assign w_tagEmpty = (r_wrPtr == r_rdPtr);
    assign w_tagFull  = (r_wrPtr[PW] != r_rdPtr[PW]) &&
                        (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]);
    assign w_headTag  = r_tagMem[r_rdPtr[PW-1:0]];
    assign w_headB    = w_headTag ? q1.b : q0.b;

    // The owner's eos token is swallowed at once. Data waits on the IDCT and
    // on tag space.
    assign w_ownB     = w_ownE ? 1'b0 : (x.b | w_tagFull);
    assign w_xFire    = w_inBurst & w_ownV & ~w_ownE & ~w_tagFull & ~x.b;
    assign w_eosTake  = w_inBurst & w_ownV & w_ownE;
    assign w_lastBeat = w_xFire & (r_count == LAST_BEAT);

    // Results with no tag to route them, and eos tokens from the IDCT, are
    // accepted and dropped.
    assign w_yRoute = y.v & ~y.e & ~w_tagEmpty;
    assign w_yFire  = w_yRoute & ~w_headB;
    assign w_yBad   = y.v & (y.e | w_tagEmpty);

    assign w_eosOut[0] = r_done[0] & (r_outst[0] == '0) & ~r_eosSent[0];
    assign w_eosOut[1] = r_done[1] & (r_outst[1] == '0) & ~r_eosSent[1];
    assign w_eosFire   = w_eosOut & ~w_qB;

    assign w_outInc = {w_xFire & r_owner, w_xFire & ~r_owner};
    assign w_outDec = {w_yFire & w_headTag, w_yFire & ~w_headTag};

    assign err = r_err;

    // State register of the arbitration FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: leave IDLE on any eligible request; leave BURST on the last beat or on eos.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (|w_elig) w_nextState = ST_BURST;
            ST_BURST: if (w_eosTake || w_lastBeat) w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Stream outputs: the owner goes to x during a burst, and results are steered by the FIFO head tag.
    always_comb begin
        x.d  = '0;
        x.v  = 1'b0;
        x.e  = 1'b0;
        r0.b = 1'b1;
        r1.b = 1'b1;
        if (w_inBurst) begin
            x.d = w_ownD;
            x.v = w_ownV & ~w_ownE & ~w_tagFull;
            if (r_owner) begin
                r1.b = w_ownB;
            end else begin
                r0.b = w_ownB;
            end
        end
        y.b  = w_yRoute ? w_headB : 1'b0;
        q0.v = w_eosOut[0] | (w_yRoute & ~w_headTag);
        q0.e = w_eosOut[0];
        q0.d = (w_yRoute & ~w_headTag) ? y.d : '0;
        q1.v = w_eosOut[1] | (w_yRoute & w_headTag);
        q1.e = w_eosOut[1];
        q1.d = (w_yRoute & w_headTag) ? y.d : '0;
    end

    // Datapath state: owner/count, retirement flags, tag FIFO, in-flight counters and sticky error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner   <= 1'b1;
            r_count   <= '0;
            r_done    <= '0;
            r_eosSent <= '0;
            r_err     <= 1'b0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            for (int i = 0; i < TAGDEPTH; i++) begin
                r_tagMem[i] <= 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                r_outst[i] <= '0;
            end
        end else begin
            if ((r_state == ST_IDLE) && (|w_elig)) begin
                r_owner <= w_grant;
                r_count <= '0;
            end else if (w_xFire) begin
                r_count <= r_count + 4'd1;
            end
            if (w_eosTake) begin
                r_done[r_owner] <= 1'b1;
            end
            r_eosSent <= r_eosSent | w_eosFire;
            if (w_yBad) begin
                r_err <= 1'b1;
            end
            if (w_xFire) begin
                r_tagMem[r_wrPtr[PW-1:0]] <= r_owner;
                r_wrPtr <= r_wrPtr + (PW+1)'(1);
            end
            if (w_yFire) begin
                r_rdPtr <= r_rdPtr + (PW+1)'(1);
            end
            for (int i = 0; i < 2; i++) begin
                if (w_outInc[i] && !w_outDec[i]) begin
                    r_outst[i] <= r_outst[i] + OW'(1);
                end else if (w_outDec[i] && !w_outInc[i]) begin
                    r_outst[i] <= r_outst[i] - OW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_illm_d1_arb.sv
// Testbench for illm_d1_arb. Two requester drivers, a loopback IDCT model
// with programmable latency, and per-requester result scoreboards run one
// cycle at a time from the main sequence.
module tb_illm_d1_arb;

    localparam int BURST    = 8;
    localparam int TAGDEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic err;

    illm_d1_arb_if r0If ();
    illm_d1_arb_if r1If ();
    illm_d1_arb_if xIf ();
    illm_d1_arb_if yIf ();
    illm_d1_arb_if q0If ();
    illm_d1_arb_if q1If ();

    illm_d1_arb #(.BURST(BURST), .TAGDEPTH(TAGDEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .r0    (r0If),
        .r1    (r1If),
        .x     (xIf),
        .y     (yIf),
        .q0    (q0If),
        .q1    (q1If),
        .err   (err)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    int           nChecks = 0;
    int           nFail   = 0;
    int           cycle   = 0;
    int           lat     = 1;
    bit           qbRand  = 1'b0;
    bit           yInject = 1'b0;
    int           sendN [2];
    int           sent [2];
    bit           sendEos [2];
    bit           eosDone [2];
    bit           pester [2];
    int           eosCount [2];
    int           pesterAcc;
    int           unexpected = 0;
    int           fullIssue  = 0;
    int           maxOut;
    bit           xeSeen = 1'b0;
    logic [127:0] curD [2];
    logic         drvV [2];
    logic         drvE [2];
    logic [127:0] drvD [2];
    logic [127:0] expQ0 [$];
    logic [127:0] expQ1 [$];
    logic [127:0] pipeD [$];
    int           pipeT [$];
    int           xOwn [$];
    int           xCyc [$];

    function automatic logic [127:0] randVec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int expOwner(int k);
`ifdef ILLM_D1_ARB_PRIO_EN
        return (k < 16) ? 0 : 1;
`else
        return (k / BURST) % 2;
`endif
    endfunction

    task automatic checkOutput(string tag, logic [127:0] obs, logic [127:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 2; i++) begin
            sendN[i]    = 0;
            sent[i]     = 0;
            sendEos[i]  = 1'b0;
            eosDone[i]  = 1'b0;
            pester[i]   = 1'b0;
            eosCount[i] = 0;
            curD[i]     = randVec();
        end
        pesterAcc = 0;
        maxOut    = 0;
        qbRand    = 1'b0;
        yInject   = 1'b0;
        expQ0.delete();
        expQ1.delete();
        xOwn.delete();
        xCyc.delete();
    endtask

    task automatic doReset();
        @(negedge clock);
        reset   = 1'b0;
        r0If.v  = 1'b0;
        r1If.v  = 1'b0;
        r0If.e  = 1'b0;
        r1If.e  = 1'b0;
        yIf.v   = 1'b0;
        xIf.b   = 1'b0;
        q0If.b  = 1'b0;
        q1If.b  = 1'b0;
        clearModel();
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One cycle: drive at the falling edge, then observe the transfers that the next rising edge commits.
    task automatic applyStimulus();
        logic [1:0]   rB;
        logic [1:0]   accD;
        logic [1:0]   accE;
        logic         xFire;
        logic         yFire;
        int           occ;
        int           src;
        logic [127:0] expD;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            drvV[i] = 1'b0;
            drvE[i] = 1'b0;
            drvD[i] = '0;
            if (sent[i] < sendN[i]) begin
                drvV[i] = 1'b1;
                drvD[i] = curD[i];
            end else if (sendEos[i] && !eosDone[i]) begin
                drvV[i] = 1'b1;
                drvE[i] = 1'b1;
            end else if (pester[i]) begin
                drvV[i] = 1'b1;
                drvD[i] = curD[i];
            end
        end
        r0If.v = drvV[0]; r0If.e = drvE[0]; r0If.d = drvD[0];
        r1If.v = drvV[1]; r1If.e = drvE[1]; r1If.d = drvD[1];
        xIf.b  = 1'b0;
        q0If.b = qbRand ? 1'($urandom_range(0, 1)) : 1'b0;
        q1If.b = qbRand ? 1'($urandom_range(0, 1)) : 1'b0;
        yIf.e  = 1'b0;
        if (yInject) begin
            yIf.v = 1'b1;
            yIf.d = randVec();
        end else if (pipeD.size() > 0 && pipeT[0] <= cycle) begin
            yIf.v = 1'b1;
            yIf.d = pipeD[0];
        end else begin
            yIf.v = 1'b0;
            yIf.d = '0;
        end
        #1;
        rB    = {r1If.b, r0If.b};
        occ   = pipeD.size();
        xFire = xIf.v & ~xIf.b;
        if (xIf.e !== 1'b0) xeSeen = 1'b1;
        if (occ >= TAGDEPTH && xIf.v) fullIssue++;
        for (int i = 0; i < 2; i++) begin
            accD[i] = drvV[i] & ~drvE[i] & ~rB[i];
            accE[i] = drvV[i] & drvE[i] & ~rB[i];
        end
        if (xFire || (accD != 2'b00)) begin
            checkOutput("x fire matches accept", xFire, |accD);
            if (xFire) begin
                src = accD[1] ? 1 : 0;
                checkOutput("x data", xIf.d, drvD[src]);
                pipeD.push_back(xIf.d);
                pipeT.push_back(cycle + lat);
                xOwn.push_back(src);
                xCyc.push_back(cycle);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (accD[i]) begin
                if (sent[i] < sendN[i]) begin
                    if (i == 0) expQ0.push_back(drvD[i]);
                    else        expQ1.push_back(drvD[i]);
                    sent[i]++;
                    curD[i] = randVec();
                end else begin
                    pesterAcc++;
                end
            end
            if (accE[i]) eosDone[i] = 1'b1;
        end
        yFire = yIf.v & ~yIf.b;
        if (yFire && !yInject && pipeD.size() > 0) begin
            void'(pipeD.pop_front());
            void'(pipeT.pop_front());
        end
        if (pipeD.size() > maxOut) maxOut = pipeD.size();
        if (q0If.v && !q0If.b) begin
            if (q0If.e) begin
                eosCount[0]++;
                checkOutput("q0 eos after data", expQ0.size(), 0);
            end else if (expQ0.size() == 0) begin
                unexpected++;
            end else begin
                expD = expQ0.pop_front();
                checkOutput("q0 data", q0If.d, expD);
            end
        end
        if (q1If.v && !q1If.b) begin
            if (q1If.e) begin
                eosCount[1]++;
                checkOutput("q1 eos after data", expQ1.size(), 0);
            end else if (expQ1.size() == 0) begin
                unexpected++;
            end else begin
                expD = expQ1.pop_front();
                checkOutput("q1 data", q1If.d, expD);
            end
        end
        cycle++;
    endtask

    function automatic bit quiet();
        for (int i = 0; i < 2; i++) begin
            if (sent[i] < sendN[i]) return 1'b0;
            if (sendEos[i] && !(eosDone[i] && eosCount[i] > 0)) return 1'b0;
        end
        return (pipeD.size() == 0) && (expQ0.size() == 0) && (expQ1.size() == 0);
    endfunction

    task automatic drain(string tag, int budget);
        int k = 0;
        while (!quiet() && k < budget) begin
            applyStimulus();
            k++;
        end
        checkOutput(tag, k < budget, 1'b1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout nChecks=%0d", nChecks);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        int start;
        int k;
        r0If.v = 1'b1; r0If.e = 1'b0; r0If.d = '1;
        r1If.v = 1'b0; r1If.e = 1'b0; r1If.d = '0;
        yIf.v  = 1'b0; yIf.e  = 1'b0; yIf.d  = '0;
        xIf.b  = 1'b0; q0If.b = 1'b0; q1If.b = 1'b0;
        clearModel();

        $display("[TB] reset values");
        #12;
        checkOutput("rst x_v", xIf.v, 1'b0);
        checkOutput("rst x_e", xIf.e, 1'b0);
        checkOutput("rst x_d", xIf.d, 128'd0);
        checkOutput("rst q0_v", q0If.v, 1'b0);
        checkOutput("rst q1_v", q1If.v, 1'b0);
        checkOutput("rst q0_e", q0If.e, 1'b0);
        checkOutput("rst q1_e", q1If.e, 1'b0);
        checkOutput("rst q0_d", q0If.d, 128'd0);
        checkOutput("rst r0_b", r0If.b, 1'b1);
        checkOutput("rst r1_b", r1If.b, 1'b1);
        checkOutput("rst y_b", yIf.b, 1'b0);
        checkOutput("rst err", err, 1'b0);
        doReset();

        $display("[TB] single requester bursts");
        lat = 1;
        sendN[0] = 16;
        start = cycle;
        drain("t1 drain", 300);
        checkOutput("t1 issue count", xCyc.size(), 16);
        checkOutput("t1 idle bubble first", xCyc[0] - start, 1);
        checkOutput("t1 burst contiguous", xCyc[7] - xCyc[0], 7);
        checkOutput("t1 bubble between bursts", xCyc[8] - xCyc[7], 2);

        $display("[TB] two requesters contending");
        doReset();
        sendN[0] = 16;
        sendN[1] = 16;
        drain("t2 drain", 400);
        checkOutput("t2 issue count", xCyc.size(), 32);
        for (int i = 0; i < 32; i++) begin
            checkOutput("t2 grant owner", xOwn[i], expOwner(i));
        end

        $display("[TB] tag FIFO limit with slow IDCT");
        doReset();
        lat = 6;
        qbRand = 1'b1;
        sendN[0] = 12;
        drain("t3 drain", 400);
        checkOutput("t3 max outstanding", maxOut, TAGDEPTH);
        checkOutput("t3 no issue while full", fullIssue, 0);
        checkOutput("t3 err clear", err, 1'b0);

        $display("[TB] end of stream on r1");
        doReset();
        lat = 3;
        sendN[1] = 3;
        sendEos[1] = 1'b1;
        drain("t4 drain", 300);
        checkOutput("t4 eos not forwarded", xCyc.size(), 3);
        checkOutput("t4 q1 eos count", eosCount[1], 1);
        pester[1] = 1'b1;
        repeat (20) applyStimulus();
        checkOutput("t4 r1 not regranted", pesterAcc, 0);
        checkOutput("t4 r1 held off", r1If.b, 1'b1);
        checkOutput("t4 single q1 eos", eosCount[1], 1);
        checkOutput("t4 no q0 eos", eosCount[0], 0);

        $display("[TB] stray result with empty FIFO");
        doReset();
        yInject = 1'b1;
        applyStimulus();
        checkOutput("t5 y_b", yIf.b, 1'b0);
        checkOutput("t5 q0_v", q0If.v, 1'b0);
        checkOutput("t5 q1_v", q1If.v, 1'b0);
        yInject = 1'b0;
        applyStimulus();
        checkOutput("t5 err set", err, 1'b1);
        repeat (5) applyStimulus();
        checkOutput("t5 err sticky", err, 1'b1);
        doReset();
        checkOutput("t5 err cleared by reset", err, 1'b0);

        $display("[TB] reset mid-burst");
        lat = 6;
        sendN[0] = 8;
        k = 0;
        while (xCyc.size() < 2 && k < 50) begin
            applyStimulus();
            k++;
        end
        checkOutput("t6 reached two issues", xCyc.size(), 2);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6 x_v", xIf.v, 1'b0);
        checkOutput("t6 x_d", xIf.d, 128'd0);
        checkOutput("t6 r0_b", r0If.b, 1'b1);
        checkOutput("t6 r1_b", r1If.b, 1'b1);
        checkOutput("t6 q0_v", q0If.v, 1'b0);
        checkOutput("t6 y_b", yIf.b, 1'b0);
        checkOutput("t6 err", err, 1'b0);
        doReset();
        drain("t6 late results drain", 100);
        checkOutput("t6 late results set err", err, 1'b1);

        checkOutput("x_e never asserted", xeSeen, 1'b0);
        checkOutput("no unexpected q data", unexpected, 0);
        checkOutput("no issue while FIFO full", fullIssue, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
